// File: rtl/tree_pkg.sv
// Shared definitions for decision-tree walkers: node word layout, tag encoding,
// walker FSM states and fp64 field masks.
package tree_pkg;

    localparam int NODE_ID_LSB = 96;
    localparam int FEAT_LSB    = 92;
    localparam int THR_LSB     = 28;
    localparam int THR_W       = 64;
    localparam int LEFT_LSB    = 16;
    localparam int RIGHT_LSB   = 4;
    localparam int TAG_LSB     = 0;
    localparam int TAG_W       = 4;

    localparam logic [TAG_W-1:0] TAG_INTERNAL = 4'h3;

    localparam logic [63:0] FP64_EXP_MASK  = 64'h7FF0_0000_0000_0000;
    localparam logic [63:0] FP64_MANT_MASK = 64'h000F_FFFF_FFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_NODE_WAIT,
        ST_NODE_EVAL,
        ST_FEAT_WAIT,
        ST_FEAT_EVAL
    } state_e;

endpackage

// File: rtl/fp64_le_cmp.sv
// Combinational a <= b on raw IEEE-754 doubles using sign-magnitude ordering.
// Any NaN operand makes the pair unordered, and le is then forced low.
module fp64_le_cmp
    import tree_pkg::*;
(
    input  logic [63:0] a,
    input  logic [63:0] b,
    output logic        le,
    output logic        unordered
);

    logic        a_nan;
    logic        b_nan;
    logic [62:0] a_mag;
    logic [62:0] b_mag;
    logic        both_zero;
    logic        ordered_le;

    assign a_nan     = ((a & FP64_EXP_MASK) == FP64_EXP_MASK) && ((a & FP64_MANT_MASK) != 64'd0);
    assign b_nan     = ((b & FP64_EXP_MASK) == FP64_EXP_MASK) && ((b & FP64_MANT_MASK) != 64'd0);
    assign a_mag     = a[62:0];
    assign b_mag     = b[62:0];
    // +0 and -0 differ only in the sign bit and must compare equal
    assign both_zero = (a_mag == 63'd0) && (b_mag == 63'd0);

    always_comb begin
        ordered_le = 1'b0;
        if (both_zero) begin
            ordered_le = 1'b1;
        end else begin
            unique case ({a[63], b[63]})
                2'b00:   ordered_le = (a_mag <= b_mag);
                2'b11:   ordered_le = (a_mag >= b_mag);
                2'b10:   ordered_le = 1'b1;
                default: ordered_le = 1'b0;
            endcase
        end
    end

    assign unordered = a_nan | b_nan;
    assign le        = ordered_le & ~unordered;

endmodule

// File: rtl/tree_walker.sv
// Walks one decision tree from the root node to a leaf, fetching nodes and
// features through 1-cycle synchronous memories, and reports the leaf class.
module tree_walker
    import tree_pkg::*;
#(
    parameter int NODE_WIDTH = 120,
    parameter int ADDR_WIDTH = 10,
    parameter int ROOT_ADDR  = 0,
    parameter int MAX_DEPTH  = 32,
    parameter int FEAT_IDX_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic                  class_out,
    output logic                  error,
    output logic [5:0]            hops,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic [NODE_WIDTH-1:0] rom_data,
    output logic [FEAT_IDX_W-1:0] feat_addr,
    input  logic [63:0]           feat_data
);

    localparam logic [ADDR_WIDTH-1:0] ROOT = ADDR_WIDTH'(ROOT_ADDR);

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] rom_addr_q, rom_addr_d;
    logic [FEAT_IDX_W-1:0] feat_addr_q, feat_addr_d;
    logic [5:0]            hops_q, hops_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  class_q, class_d;
    logic                  error_q, error_d;
    logic [THR_W-1:0]      thr_q, thr_d;
    logic [ADDR_WIDTH-1:0] left_q, left_d;
    logic [ADDR_WIDTH-1:0] right_q, right_d;

    logic [ADDR_WIDTH-1:0] node_id;
    logic [TAG_W-1:0]      node_tag;
    logic [6:0]            hops_inc;
    logic [ADDR_WIDTH-1:0] child;
    logic                  feat_le;
    logic                  feat_unord;
    logic                  finish;
    logic                  abort;
    logic                  unused_rom;

    assign node_id    = rom_data[NODE_ID_LSB +: ADDR_WIDTH];
    assign node_tag   = rom_data[TAG_LSB +: TAG_W];
    assign hops_inc   = {1'b0, hops_q} + 7'd1;
    assign child      = (feat_le && !feat_unord) ? left_q : right_q;
    assign unused_rom = ^rom_data;

    fp64_le_cmp u_cmp (
        .a         (feat_data),
        .b         (thr_q),
        .le        (feat_le),
        .unordered (feat_unord)
    );

    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        feat_addr_d = feat_addr_q;
        hops_d      = hops_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        class_d     = class_q;
        error_d     = error_q;
        thr_d       = thr_q;
        left_d      = left_q;
        right_d     = right_q;
        finish      = 1'b0;
        abort       = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    rom_addr_d = ROOT;
                    hops_d     = 6'd0;
                    busy_d     = 1'b1;
                    state_d    = ST_NODE_WAIT;
                end
            end
            ST_NODE_WAIT: state_d = ST_NODE_EVAL;
            ST_NODE_EVAL: begin
                // The node_id self-check catches a walk that jumped into the wrong word
                if (node_id != rom_addr_q) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else if (node_tag != TAG_INTERNAL) begin
                    finish  = 1'b1;
                    class_d = node_tag[0];
                end else begin
                    thr_d       = rom_data[THR_LSB +: THR_W];
                    left_d      = rom_data[LEFT_LSB +: ADDR_WIDTH];
                    right_d     = rom_data[RIGHT_LSB +: ADDR_WIDTH];
                    feat_addr_d = rom_data[FEAT_LSB +: FEAT_IDX_W];
                    state_d     = ST_FEAT_WAIT;
                end
            end
            ST_FEAT_WAIT: state_d = ST_FEAT_EVAL;
            ST_FEAT_EVAL: begin
                // Depth overrun leaves hops at the last evaluation that was allowed
                if (hops_inc > 7'(MAX_DEPTH)) begin
                    finish = 1'b1;
                    abort  = 1'b1;
                end else begin
                    hops_d = hops_inc[5:0];
                    if (child == ROOT) begin
                        finish = 1'b1;
                        abort  = 1'b1;
                    end else begin
                        rom_addr_d = child;
                        state_d    = ST_NODE_WAIT;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (finish) begin
            done_d  = 1'b1;
            busy_d  = 1'b0;
            error_d = abort;
            state_d = ST_IDLE;
            if (abort) begin
                class_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            rom_addr_q  <= ROOT;
            feat_addr_q <= '0;
            hops_q      <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            class_q     <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            feat_addr_q <= feat_addr_d;
            hops_q      <= hops_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            class_q     <= class_d;
            error_q     <= error_d;
        end
    end

    // Node field latches are pure data and need no reset
    always_ff @(posedge clk) begin
        thr_q   <= thr_d;
        left_q  <= left_d;
        right_q <= right_d;
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign class_out = class_q;
    assign error     = error_q;
    assign hops      = hops_q;
    assign rom_addr  = rom_addr_q;
    assign feat_addr = feat_addr_q;

endmodule

// File: tb/tb_tree_walker.sv
// Directed bench for tree_walker: behavioural node ROM and feature file, a
// vector table of root-threshold comparisons, and hand-written control cases.
module tb_tree_walker;

    localparam int AW = 10;
    localparam logic [63:0] THR = 64'h4068_1000_0000_0000;  // 192.5

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          busy, done, class_out, error;
    logic [5:0]    hops;
    logic [AW-1:0] rom_addr;
    logic [119:0]  rom_data = '0;
    logic [3:0]    feat_addr;
    logic [63:0]   feat_data = '0;

    logic [119:0]  rom [0:1023];
    logic [63:0]   feat [0:15];

    int checks = 0;
    int failures = 0;

    tree_walker #(
        .NODE_WIDTH (120),
        .ADDR_WIDTH (AW),
        .ROOT_ADDR  (0),
        .MAX_DEPTH  (4),
        .FEAT_IDX_W (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .class_out (class_out),
        .error     (error),
        .hops      (hops),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .feat_addr (feat_addr),
        .feat_data (feat_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        rom_data  <= rom[rom_addr];
        feat_data <= feat[feat_addr];
    end

    function automatic logic [119:0] mk_node(input logic [11:0] id, input logic [3:0] fidx,
                                             input logic [63:0] thr, input logic [11:0] l,
                                             input logic [11:0] r, input logic [3:0] tag);
        return {12'h000, id, fidx, thr, l, r, tag};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pulses start for one cycle; lat = edges after the sampling edge until done
    task automatic run_walk(output int lat);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic std_tree();
        rom[0] = mk_node(12'd0, 4'd1, THR, 12'd1, 12'd2, 4'h3);
        rom[1] = mk_node(12'd1, 4'd0, 64'd0, 12'd0, 12'd0, 4'h1);
        rom[2] = mk_node(12'd2, 4'd0, 64'd0, 12'd0, 12'd0, 4'h0);
    endtask

    typedef struct {
        logic [63:0] thr;
        logic [63:0] fv;
        logic        exp_class;
    } vec_t;

    vec_t vecs [11];

    initial begin
        int lat;
        int seen;

        for (int i = 0; i < 1024; i++) rom[i] = '0;
        for (int i = 0; i < 16; i++) feat[i] = '0;
        std_tree();

        vecs[0]  = '{THR, 64'h4060_0000_0000_0000, 1'b1};                    // 128 <= 192.5
        vecs[1]  = '{THR, 64'h4070_0000_0000_0000, 1'b0};                    // 256 > 192.5
        vecs[2]  = '{THR, THR, 1'b1};                                        // equal goes left
        vecs[3]  = '{THR, 64'hC072_C000_0000_0000, 1'b1};                    // -300
        vecs[4]  = '{64'h0, 64'h8000_0000_0000_0000, 1'b1};                  // -0 vs +0
        vecs[5]  = '{THR, 64'h7FF8_0000_0000_0000, 1'b0};                    // NaN
        vecs[6]  = '{64'hBFF0_0000_0000_0000, 64'hC000_0000_0000_0000, 1'b1}; // -2 <= -1
        vecs[7]  = '{64'hC000_0000_0000_0000, 64'hBFF0_0000_0000_0000, 1'b0}; // -1 > -2
        vecs[8]  = '{64'h8000_0000_0000_0000, 64'h0, 1'b1};                  // +0 vs -0
        vecs[9]  = '{THR, 64'hFFF8_0000_0000_0000, 1'b0};                    // negative NaN
        vecs[10] = '{64'h7FF0_0000_0000_0000, 64'h7FE0_0000_0000_0000, 1'b1}; // finite <= +inf

        // Reset values
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_class", class_out, 0);
        chk("rst_error", error, 0);
        chk("rst_hops", hops, 0);
        chk("rst_rom_addr", rom_addr, 0);
        chk("rst_feat_addr", feat_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 11; i++) begin
            rom[0] = mk_node(12'd0, 4'd1, vecs[i].thr, 12'd1, 12'd2, 4'h3);
            feat[1] = vecs[i].fv;
            run_walk(lat);
            chk($sformatf("v%0d_latency", i), lat, 6);
            chk($sformatf("v%0d_class", i), class_out, vecs[i].exp_class);
            chk($sformatf("v%0d_error", i), error, 0);
            chk($sformatf("v%0d_hops", i), hops, 1);
            chk($sformatf("v%0d_busy_at_done", i), busy, 0);
            if (i == 0) chk("v0_feat_addr", feat_addr, 1);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_done_pulse", i), done, 0);
        end

        // Corrupted node_id on the leaf
        std_tree();
        feat[1] = 64'h4060_0000_0000_0000;
        run_walk(lat);
        chk("pre_id_class", class_out, 1);
        rom[1] = mk_node(12'd5, 4'd0, 64'd0, 12'd0, 12'd0, 4'h1);
        run_walk(lat);
        chk("badid_latency", lat, 6);
        chk("badid_error", error, 1);
        chk("badid_class", class_out, 0);

        // Self-loop exceeding MAX_DEPTH=4
        std_tree();
        run_walk(lat);
        chk("pre_loop_class", class_out, 1);
        rom[1] = mk_node(12'd1, 4'd1, THR, 12'd1, 12'd1, 4'h3);
        run_walk(lat);
        chk("loop_latency", lat, 20);
        chk("loop_error", error, 1);
        chk("loop_class", class_out, 0);
        chk("loop_hops", hops, 4);

        // Child pointing back to root
        std_tree();
        run_walk(lat);
        chk("pre_root_class", class_out, 1);
        chk("error_cleared", error, 0);
        rom[0] = mk_node(12'd0, 4'd1, THR, 12'd0, 12'd2, 4'h3);
        run_walk(lat);
        chk("rootchild_latency", lat, 4);
        chk("rootchild_error", error, 1);
        chk("rootchild_class", class_out, 0);

        // Root is itself a leaf
        std_tree();
        run_walk(lat);
        chk("pre_leaf_hops", hops, 1);
        rom[0] = mk_node(12'd0, 4'd0, 64'd0, 12'd0, 12'd0, 4'h1);
        run_walk(lat);
        chk("rootleaf_latency", lat, 2);
        chk("rootleaf_hops", hops, 0);
        chk("rootleaf_class", class_out, 1);
        chk("rootleaf_error", error, 0);

        // Asynchronous reset during FEAT_WAIT
        std_tree();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_rst_busy", busy, 1);
        chk("pre_rst_feat_addr", feat_addr, 1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_class", class_out, 0);
        chk("arst_hops", hops, 0);
        chk("arst_feat_addr", feat_addr, 0);
        chk("arst_rom_addr", rom_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        chk("arst_no_done", seen, 0);

        // start held high during a walk
        feat[1] = 64'h4070_0000_0000_0000;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        #1;
        chk("held_done_edge6", done, 1);
        chk("held_class", class_out, 0);
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) seen++;
        end
        chk("held_no_restart", seen, 0);

        // Back-to-back: start in the cycle after done
        feat[1] = 64'h4060_0000_0000_0000;
        run_walk(lat);
        chk("b2b_first_class", class_out, 1);
        feat[1] = 64'h4070_0000_0000_0000;
        @(posedge clk);
        #1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("b2b_busy", busy, 1);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("b2b_latency", lat, 6);
        chk("b2b_second_class", class_out, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
